// File: rtl/msix_table_pba.sv
// rtl/msix_table_pba.sv - MSI-X table and pending bit array with interrupt issue engine
module msix_table_pba #(
    parameter int                NUM_VECTORS  = 16,
    parameter int                ADDR_W       = 12,
    parameter logic [ADDR_W-1:0] TABLE_OFFSET = 12'h000,
    parameter logic [ADDR_W-1:0] PBA_OFFSET   = 12'h800,
    localparam int               VEC_W        = (NUM_VECTORS > 1) ? $clog2(NUM_VECTORS) : 1
) (
    input  logic              clk_pcie,
    input  logic              rst,
    input  logic              wr_valid,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [31:0]       wr_data,
    input  logic [3:0]        wr_be,
    input  logic              rd_req_valid,
    output logic              rd_req_ready,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_cpl_valid,
    output logic [31:0]       rd_cpl_data,
    input  logic              rd_cpl_ready,
    input  logic              msix_enable,
    input  logic              function_mask,
    input  logic              irq_valid,
    input  logic [VEC_W-1:0]  irq_vector,
    output logic              irq_ready,
    output logic              msg_valid,
    output logic [63:0]       msg_addr,
    output logic [31:0]       msg_data,
    input  logic              msg_ready,
    output logic [NUM_VECTORS-1:0] pba
);
    localparam int PBA_DW = (NUM_VECTORS + 31) / 32;

    typedef enum logic [1:0] {S_IDLE, S_EVAL, S_ISSUE} state_t;

    logic [31:0]            addr_lo [NUM_VECTORS];
    logic [31:0]            addr_hi [NUM_VECTORS];
    logic [31:0]            data_q  [NUM_VECTORS];
    logic [NUM_VECTORS-1:0] mask_q;
    logic [NUM_VECTORS-1:0] pba_q;
    logic [63:0]            pba_ext;

    state_t            state, state_nxt;
    logic [VEC_W-1:0]  cur_vec, scan_vec;
    logic              cur_ok;
    logic              latch_irq, latch_scan, do_set, do_issue;

    logic [ADDR_W-1:0] wr_rel, rd_tbl_rel, rd_pba_rel;
    logic              wr_tbl_hit, rd_tbl_hit, rd_pba_hit;
    logic [VEC_W-1:0]  wr_idx, rd_idx;
    logic [31:0]       rd_word;
    logic              unused_bits;

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++)
            if (be[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    assign wr_rel     = wr_addr - TABLE_OFFSET;
    assign rd_tbl_rel = rd_addr - TABLE_OFFSET;
    assign rd_pba_rel = rd_addr - PBA_OFFSET;
    assign wr_tbl_hit = (wr_addr >= TABLE_OFFSET) && ((wr_rel >> 4) < ADDR_W'(NUM_VECTORS));
    assign rd_tbl_hit = (rd_addr >= TABLE_OFFSET) && ((rd_tbl_rel >> 4) < ADDR_W'(NUM_VECTORS));
    assign rd_pba_hit = (rd_addr >= PBA_OFFSET) && ((rd_pba_rel >> 2) < ADDR_W'(PBA_DW));
    assign wr_idx     = wr_rel[4 +: VEC_W];
    assign rd_idx     = rd_tbl_rel[4 +: VEC_W];
    assign pba_ext    = 64'(pba_q);
    assign unused_bits = ^{wr_rel[1:0], rd_tbl_rel[1:0], rd_pba_rel[1:0]};

    always_comb begin
        rd_word = 32'h0;
        if (rd_tbl_hit) begin
            case (rd_tbl_rel[3:2])
                2'd0:    rd_word = addr_lo[rd_idx];
                2'd1:    rd_word = addr_hi[rd_idx];
                2'd2:    rd_word = data_q[rd_idx];
                default: rd_word = {31'b0, mask_q[rd_idx]};
            endcase
        end else if (rd_pba_hit) begin
            rd_word = rd_pba_rel[2] ? pba_ext[63:32] : pba_ext[31:0];
        end
    end

    // Table writes; PBA and unmapped writes fall through untouched
    always_ff @(posedge clk_pcie) begin
        if (rst) begin
            for (int n = 0; n < NUM_VECTORS; n++) begin
                addr_lo[n] <= '0;
                addr_hi[n] <= '0;
                data_q[n]  <= '0;
            end
            mask_q <= '1;
        end else if (wr_valid && wr_tbl_hit) begin
            case (wr_rel[3:2])
                2'd0:    addr_lo[wr_idx] <= merge(addr_lo[wr_idx], wr_data, wr_be) & 32'hFFFF_FFFC;
                2'd1:    addr_hi[wr_idx] <= merge(addr_hi[wr_idx], wr_data, wr_be);
                2'd2:    data_q[wr_idx]  <= merge(data_q[wr_idx], wr_data, wr_be);
                default: if (wr_be[0]) mask_q[wr_idx] <= wr_data[0];
            endcase
        end
    end

    assign rd_req_ready = !rd_cpl_valid;

    always_ff @(posedge clk_pcie) begin
        if (rst) begin
            rd_cpl_valid <= 1'b0;
            rd_cpl_data  <= '0;
        end else if (rd_req_valid && rd_req_ready) begin
            rd_cpl_valid <= 1'b1;
            rd_cpl_data  <= rd_word;
        end else if (rd_cpl_valid && rd_cpl_ready) begin
            rd_cpl_valid <= 1'b0;
        end
    end

    always_comb begin
        scan_vec = '0;
        for (int n = NUM_VECTORS - 1; n >= 0; n--)
            if (pba_q[n] && !mask_q[n]) scan_vec = VEC_W'(n);
    end

    assign cur_ok = (32'(cur_vec) < NUM_VECTORS);

    always_ff @(posedge clk_pcie) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        irq_ready  = 1'b0;
        latch_irq  = 1'b0;
        latch_scan = 1'b0;
        do_set     = 1'b0;
        do_issue   = 1'b0;
        case (state)
            S_IDLE: begin
                irq_ready = !rst;
                if (irq_valid) begin
                    latch_irq = 1'b1;
                    state_nxt = S_EVAL;
                end else if (msix_enable && !function_mask && |(pba_q & ~mask_q)) begin
                    latch_scan = 1'b1;
                    state_nxt  = S_EVAL;
                end
            end
            S_EVAL: begin
                state_nxt = S_IDLE;
                if (msix_enable && cur_ok) begin
                    if (function_mask || mask_q[cur_vec]) begin
                        do_set = 1'b1;
                    end else begin
                        do_issue  = 1'b1;
                        state_nxt = S_ISSUE;
                    end
                end
            end
            S_ISSUE: if (msg_ready) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Payload is snapshotted at evaluation so later table writes cannot disturb it
    always_ff @(posedge clk_pcie) begin
        if (rst) begin
            cur_vec   <= '0;
            pba_q     <= '0;
            msg_valid <= 1'b0;
            msg_addr  <= '0;
            msg_data  <= '0;
        end else begin
            if (latch_irq)       cur_vec <= irq_vector;
            else if (latch_scan) cur_vec <= scan_vec;
            if (do_set) pba_q[cur_vec] <= 1'b1;
            if (do_issue) begin
                pba_q[cur_vec] <= 1'b0;
                msg_valid      <= 1'b1;
                msg_addr       <= {addr_hi[cur_vec], addr_lo[cur_vec]};
                msg_data       <= data_q[cur_vec];
            end else if (msg_valid && msg_ready) begin
                msg_valid <= 1'b0;
            end
        end
    end

    assign pba = pba_q;
endmodule

// File: tb/tb_msix_table_pba.sv
// tb/tb_msix_table_pba.sv - randomized and directed bench for msix_table_pba
module tb_msix_table_pba;
    localparam int N = 16;

    logic        clk_pcie = 1'b0;
    logic        rst;
    logic        wr_valid;
    logic [11:0] wr_addr;
    logic [31:0] wr_data;
    logic [3:0]  wr_be;
    logic        rd_req_valid;
    logic        rd_req_ready;
    logic [11:0] rd_addr;
    logic        rd_cpl_valid;
    logic [31:0] rd_cpl_data;
    logic        rd_cpl_ready;
    logic        msix_enable;
    logic        function_mask;
    logic        irq_valid;
    logic [3:0]  irq_vector;
    logic        irq_ready;
    logic        msg_valid;
    logic [63:0] msg_addr;
    logic [31:0] msg_data;
    logic        msg_ready;
    logic [N-1:0] pba;

    always #5 clk_pcie = ~clk_pcie;

    msix_table_pba dut (
        .clk_pcie(clk_pcie), .rst(rst),
        .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
        .rd_req_valid(rd_req_valid), .rd_req_ready(rd_req_ready), .rd_addr(rd_addr),
        .rd_cpl_valid(rd_cpl_valid), .rd_cpl_data(rd_cpl_data), .rd_cpl_ready(rd_cpl_ready),
        .msix_enable(msix_enable), .function_mask(function_mask),
        .irq_valid(irq_valid), .irq_vector(irq_vector), .irq_ready(irq_ready),
        .msg_valid(msg_valid), .msg_addr(msg_addr), .msg_data(msg_data), .msg_ready(msg_ready),
        .pba(pba)
    );

    int total = 0;
    int bad   = 0;

    // Reference: table contents plus queues of outstanding work
    logic [31:0]  m_lo [N];
    logic [31:0]  m_hi [N];
    logic [31:0]  m_dat[N];
    logic [N-1:0] m_mask;
    logic [N-1:0] m_pba;
    int           job_q[$];
    logic [95:0]  msg_q[$];
    logic [31:0]  rd_q[$];

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < N; i++) begin
            m_lo[i] = '0; m_hi[i] = '0; m_dat[i] = '0;
        end
        m_mask = '1;
        m_pba  = '0;
        job_q.delete();
        msg_q.delete();
        rd_q.delete();
    endfunction

    function automatic logic [31:0] model_read(input logic [11:0] a);
        int ai = int'(a);
        logic [63:0] p = 64'(m_pba);
        int e, k;
        if (ai < 16 * N) begin
            e = ai / 16;
            k = (ai / 4) % 4;
            case (k)
                0:       return m_lo[e];
                1:       return m_hi[e];
                2:       return m_dat[e];
                default: return {31'b0, m_mask[e]};
            endcase
        end
        if (ai >= 'h800 && ai < 'h800 + 4 * ((N + 31) / 32)) begin
            k = (ai - 'h800) / 4;
            return (k == 0) ? p[31:0] : p[63:32];
        end
        return 32'h0;
    endfunction

    function automatic void model_write(input logic [11:0] a, input logic [31:0] d,
                                        input logic [3:0] be);
        int ai = int'(a);
        int e, k;
        logic [31:0] nw;
        if (ai >= 16 * N) return;
        e = ai / 16;
        k = (ai / 4) % 4;
        case (k)
            0:       nw = m_lo[e];
            1:       nw = m_hi[e];
            2:       nw = m_dat[e];
            default: nw = {31'b0, m_mask[e]};
        endcase
        for (int b = 0; b < 4; b++)
            if (be[b]) nw[8*b +: 8] = d[8*b +: 8];
        case (k)
            0:       m_lo[e]   = nw & 32'hFFFF_FFFC;
            1:       m_hi[e]   = nw;
            2:       m_dat[e]  = nw;
            default: m_mask[e] = nw[0];
        endcase
    endfunction

    function automatic void model_step();
        logic        idle;
        logic        rd_acc;
        logic [31:0] rdv;
        int          v;
        if (rst) begin
            model_reset();
            return;
        end
        idle   = (job_q.size() == 0) && (msg_q.size() == 0);
        rd_acc = rd_req_valid && (rd_q.size() == 0);
        rdv    = model_read(rd_addr);
        if (msg_q.size() > 0 && msg_ready) void'(msg_q.pop_front());
        if (job_q.size() > 0) begin
            v = job_q.pop_front();
            if (msix_enable && v < N) begin
                if (function_mask || m_mask[v]) begin
                    m_pba[v] = 1'b1;
                end else begin
                    msg_q.push_back({m_hi[v], m_lo[v], m_dat[v]});
                    m_pba[v] = 1'b0;
                end
            end
        end
        if (idle) begin
            if (irq_valid) begin
                job_q.push_back(int'(irq_vector));
            end else if (msix_enable && !function_mask) begin
                for (int n = 0; n < N; n++)
                    if (m_pba[n] && !m_mask[n]) begin
                        job_q.push_back(n);
                        break;
                    end
            end
        end
        if (rd_q.size() > 0 && rd_cpl_ready) void'(rd_q.pop_front());
        if (rd_acc) rd_q.push_back(rdv);
        if (wr_valid) model_write(wr_addr, wr_data, wr_be);
    endfunction

    task automatic compare_all();
        check("msg_valid", 96'(msg_valid), 96'(msg_q.size() > 0));
        if (msg_q.size() > 0) check("msg_payload", {msg_addr, msg_data}, msg_q[0]);
        check("rd_cpl_valid", 96'(rd_cpl_valid), 96'(rd_q.size() > 0));
        check("rd_req_ready", 96'(rd_req_ready), 96'(rd_q.size() == 0));
        if (rd_q.size() > 0) check("rd_cpl_data", 96'(rd_cpl_data), 96'(rd_q[0]));
        check("irq_ready", 96'(irq_ready),
              96'(!rst && job_q.size() == 0 && msg_q.size() == 0));
        check("pba", 96'(pba), 96'(m_pba));
    endtask

    task automatic step();
        @(posedge clk_pcie);
        model_step();
        @(negedge clk_pcie);
        compare_all();
    endtask

    task automatic wr(input logic [11:0] a, input logic [31:0] d, input logic [3:0] be);
        wr_valid = 1'b1; wr_addr = a; wr_data = d; wr_be = be;
        step();
        wr_valid = 1'b0;
    endtask

    task automatic read_lit(input string name, input logic [11:0] a, input logic [31:0] exp);
        rd_req_valid = 1'b1; rd_addr = a;
        step();
        rd_req_valid = 1'b0;
        check(name, 96'(rd_cpl_data), 96'(exp));
        rd_cpl_ready = 1'b1;
        step();
        rd_cpl_ready = 1'b0;
    endtask

    task automatic irq(input logic [3:0] v);
        irq_valid = 1'b1; irq_vector = v;
        step();
        irq_valid = 1'b0;
    endtask

    task automatic wait_msg(input string name);
        int i = 0;
        while (!msg_valid && i < 20) begin
            step();
            i++;
        end
        check(name, 96'(msg_valid), 96'(1));
    endtask

    task automatic take_msg();
        msg_ready = 1'b1;
        step();
        msg_ready = 1'b0;
    endtask

    task automatic quiesce();
        int i = 0;
        wr_valid = 0; irq_valid = 0; rd_req_valid = 0;
        msg_ready = 1; rd_cpl_ready = 1;
        while (i < 200 && !(job_q.size() == 0 && msg_q.size() == 0 && rd_q.size() == 0
                            && (!msix_enable || function_mask || (m_pba & ~m_mask) == 0))) begin
            step();
            i++;
        end
        check("quiesce_timeout", 96'(i < 200), 96'(1));
        msg_ready = 0; rd_cpl_ready = 0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [11:0] a;
        rst = 1; wr_valid = 0; wr_addr = 0; wr_data = 0; wr_be = 0;
        rd_req_valid = 0; rd_addr = 0; rd_cpl_ready = 0;
        msix_enable = 0; function_mask = 0; irq_valid = 0; irq_vector = 0; msg_ready = 0;
        repeat (3) step();
        check("rst_irq_ready", 96'(irq_ready), 96'(0));
        check("rst_rd_req_ready", 96'(rd_req_ready), 96'(1));
        check("rst_msg_addr", 96'(msg_addr), 96'(0));
        rst = 0;
        step();

        read_lit("rst_e0_ctrl", 12'h00C, 32'h1);
        read_lit("rst_e3_addr", 12'h030, 32'h0);
        read_lit("rst_pba0", 12'h800, 32'h0);
        read_lit("rst_unmapped", 12'hFFC, 32'h0);

        // Entry 2 unmasked: two-cycle latency and stable payload under backpressure
        wr(12'h020, 32'hFEE0_0000, 4'hF);
        wr(12'h024, 32'h0000_0001, 4'hF);
        wr(12'h028, 32'h0000_0042, 4'hF);
        wr(12'h02C, 32'h0, 4'hF);
        msix_enable = 1;
        irq(4'd2);
        check("lat_not_yet", 96'(msg_valid), 96'(0));
        step();
        check("lat_2", 96'(msg_valid), 96'(1));
        for (int i = 0; i < 5; i++) begin
            check("e2_payload", {msg_addr, msg_data}, {64'h0000_0001_FEE0_0000, 32'h42});
            step();
        end
        take_msg();
        check("e2_done", 96'(msg_valid), 96'(0));
        check("e2_pba", 96'(pba), 96'(0));

        // Entry 5 masked goes pending, then unmasking releases it
        wr(12'h050, 32'h0000_1000, 4'hF);
        wr(12'h058, 32'h0000_0055, 4'hF);
        irq(4'd5);
        step();
        step();
        check("e5_no_msg", 96'(msg_valid), 96'(0));
        check("e5_pba", 96'(pba), 96'(16'h0020));
        read_lit("e5_pba_rd", 12'h800, 32'h20);
        wr(12'h05C, 32'h0, 4'hF);
        wait_msg("e5_msg_wait");
        check("e5_payload", {msg_addr, msg_data}, {64'h1000, 32'h55});
        take_msg();
        check("e5_pba_clr", 96'(pba), 96'(0));

        // Function mask holds vectors 1 and 3 pending; release in ascending order
        function_mask = 1;
        wr(12'h018, 32'h11, 4'hF); wr(12'h01C, 32'h0, 4'hF);
        wr(12'h038, 32'h33, 4'hF); wr(12'h03C, 32'h0, 4'hF);
        irq(4'd1);
        step();
        irq(4'd3);
        step();
        check("fm_pba", 96'(pba), 96'(16'h000A));
        function_mask = 0;
        wait_msg("fm_msg1_wait");
        check("fm_msg1", 96'(msg_data), 96'(32'h11));
        take_msg();
        wait_msg("fm_msg3_wait");
        check("fm_msg3", 96'(msg_data), 96'(32'h33));
        take_msg();
        step();
        check("fm_pba_clr", 96'(pba), 96'(0));

        // Disabled: request is swallowed; then a single-byte write
        msix_enable = 0;
        irq(4'd2);
        step();
        step();
        check("dis_no_msg", 96'(msg_valid), 96'(0));
        check("dis_pba", 96'(pba), 96'(0));
        wr(12'h028, 32'h0000_AB00, 4'b0010);
        read_lit("byte_wr", 12'h028, 32'h0000_AB42);
        msix_enable = 1;

        for (int c = 0; c < 3000; c++) begin
            wr_valid = ($urandom_range(0, 3) == 0);
            case ($urandom_range(0, 5))
                0:       a = 12'($urandom_range(12'h800, 12'h80F));
                1:       a = 12'($urandom);
                default: a = 12'($urandom_range(0, 16 * N + 15));
            endcase
            wr_addr = a;
            wr_data = ($urandom_range(0, 1) == 0) ? {$urandom} & 32'hFFFF_FFFE : $urandom;
            wr_be   = 4'($urandom);
            irq_valid    = ($urandom_range(0, 2) == 0);
            irq_vector   = 4'($urandom);
            msg_ready    = ($urandom_range(0, 1) == 0);
            rd_req_valid = ($urandom_range(0, 2) == 0);
            case ($urandom_range(0, 3))
                0:       rd_addr = 12'($urandom_range(12'h800, 12'h80F));
                1:       rd_addr = 12'($urandom);
                default: rd_addr = 12'($urandom_range(0, 16 * N + 15));
            endcase
            rd_cpl_ready = ($urandom_range(0, 1) == 0);
            if ($urandom_range(0, 49) == 0) msix_enable = ~msix_enable;
            if ($urandom_range(0, 39) == 0) function_mask = ~function_mask;
            step();
        end

        // Reset while a message and a read completion are both held
        msix_enable = 1; function_mask = 0;
        quiesce();
        wr(12'h02C, 32'h0, 4'hF);
        irq_valid = 1; irq_vector = 4'd2;
        step();
        irq_valid = 0;
        wait_msg("rst_msg_wait");
        rd_req_valid = 1; rd_addr = 12'h00C;
        step();
        rd_req_valid = 0;
        check("pre_rst_rd", 96'(rd_cpl_valid), 96'(1));
        rst = 1;
        step();
        check("mid_rst_msg", 96'(msg_valid), 96'(0));
        check("mid_rst_rd", 96'(rd_cpl_valid), 96'(0));
        check("mid_rst_pba", 96'(pba), 96'(0));
        rst = 0;
        step();
        for (int i = 0; i < N; i++) read_lit("rst_mask", 12'(16 * i + 12), 32'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/msix_table_pba.md
Name: msix_table_pba

Overview:
- Host-facing target side of MSI-X: owns the MSI-X Table and Pending Bit Array (PBA) behind a BAR window.
- Services host MMIO dword writes and reads to those structures.
- Accepts per-vector interrupt requests from device logic and applies enable/mask/pending rules.
- Emits fully resolved (address, data) message requests to the memory-write generator.

Parameters:
- NUM_VECTORS, 16, number of table entries / PBA bits (1..64).
- TABLE_OFFSET, 12'h000, byte offset of the table within the BAR window.
- PBA_OFFSET, 12'h800, byte offset of the PBA within the BAR window.
- ADDR_W, 12, width of the BAR-relative byte address.

Ports:
- clk_pcie  in  1  clock
- rst  in  1  synchronous, active-high reset
- wr_valid  in  1  host MMIO dword write strobe (single cycle, always accepted)
- wr_addr  in  ADDR_W  BAR-relative byte address; bits [1:0] ignored
- wr_data  in  32  write data
- wr_be  in  4  byte enables
- rd_req_valid  in  1  host MMIO dword read request
- rd_req_ready  out  1  read request accepted
- rd_addr  in  ADDR_W  BAR-relative byte address; bits [1:0] ignored
- rd_cpl_valid  out  1  read data valid
- rd_cpl_data  out  32  read data
- rd_cpl_ready  in  1  read data consumed
- msix_enable  in  1  MSI-X Enable bit from config space
- function_mask  in  1  Function Mask bit from config space
- irq_valid  in  1  device interrupt request
- irq_vector  in  $clog2(NUM_VECTORS)  requested vector
- irq_ready  out  1  request accepted
- msg_valid  out  1  message request to the memory-write generator
- msg_addr  out  64  message address
- msg_data  out  32  message data
- msg_ready  in  1  generator accepted the message
- pba  out  NUM_VECTORS  live pending bits

Behaviour:
- Table entry n occupies TABLE_OFFSET+16n: dword0 addr[31:0] (bits [1:0] forced 0), dword1 addr[63:32], dword2 data, dword3 vector control (bit0 = mask; other bits RO 0).
- Reset state: all addr and data fields 0; all masks 1; pba 0.
- Reset outputs: rd_cpl_valid=0, rd_cpl_data=0, msg_valid=0, msg_addr=0, msg_data=0, irq_ready=0, rd_req_ready=1.
- Writes: apply per byte enable in the same cycle; visible to reads and the FSM from the next cycle.
  - Writes to the PBA are ignored.
  - Writes outside table/PBA ranges, or to entry index ≥NUM_VECTORS, are ignored.
- Reads: rd_req_ready = !rd_cpl_valid. An accepted read asserts rd_cpl_valid on the next cycle; data is held stable until rd_cpl_ready.
  - PBA dword k returns pba[32k+31:32k], zero-extended beyond NUM_VECTORS.
  - Unmapped addresses return 32'h0.
- Interrupt FSM states and transitions:
  - IDLE: irq_ready=1. An irq_valid&&irq_ready handshake latches irq_vector and goes to EVAL. Otherwise, if msix_enable && !function_mask and any pba[n] has mask[n]==0, latch the lowest such n, mark it as a pending source, and go to EVAL.
  - Arbitration: a pending scan only starts on a cycle with no irq handshake, so a new request wins that cycle. The scan then runs on the next idle cycle.
  - EVAL (1 cycle, irq_ready=0):
    - If !msix_enable, drop the event (a pending source's bit is left set) → IDLE.
    - Else if function_mask or mask[v], set pba[v] → IDLE.
    - Else snapshot addr[v]/data[v] into msg_addr/msg_data, assert msg_valid, clear pba[v] → ISSUE.
  - ISSUE: hold msg_valid and payload stable until msg_ready; on the handshake deassert msg_valid → IDLE.
- Snapshot rule: table writes or mask changes after EVAL do not alter or cancel an in-flight message.
- Pending bits persist across msix_enable deassertion.
- Out-of-range irq_vector (≥NUM_VECTORS): accepted and dropped.
- Latency: irq handshake to msg_valid = 2 cycles when unmasked.
- Reset mid-operation: all state returns to reset values, msg_valid and rd_cpl_valid drop the same cycle, and table contents are reinitialised.

Test Plan:
- Read after reset → entry 0 dword3 reads 32'h1; entry 3 dword0 reads 0; PBA dword0 reads 0; offset 12'hFFC reads 0.
- Program entry 2: addr 64'h0000_0001_FEE0_0000, data 32'h0000_0042, mask=0; msix_enable=1; irq_vector=2 → msg_valid 2 cycles later with those values. Hold msg_ready low 5 cycles → payload stable; after the handshake, pba=0.
- Entry 5 masked, irq_vector=5 → no msg, pba[5]=1, PBA read = 32'h20. Write dword3=0 → message for entry 5 issued, pba[5] cleared.
- function_mask=1 with irqs on vectors 1 and 3 → pba=16'h000A. Clear function_mask → messages for vector 1 then vector 3, pba=0.
- msix_enable=0 with irq_vector=2 → irq accepted, no msg, pba unchanged. Partial write wr_be=4'b0010, wr_data=32'h0000_AB00 to entry 2 data → reads 32'h0000_AB42.
- Assert rst while msg_valid is held (msg_ready=0) → msg_valid=0 next cycle, all masks read 1, pba=0.
